decoder3_8_stream: RTL and testbench
====================================

# decoder3_8_stream

Registered 3-to-8 one-hot decoder with a valid/ready stream interface and a two-entry skid buffer. It is the inverse of the team's 8-to-3 priority encoder: it turns an index plus a "none" flag back into an 8-bit one-hot word. The none flag removes the encoder's ambiguity between input 8'h01 and input 8'h00. It sits downstream of encoder-based select/arbitration logic and drives one-hot enables into consumers that may stall. It also keeps a wrapping count of delivered words for debug.

## Interface
- IDX_W, default 3: index width; output width OUT_W = 2**IDX_W (8 at default).
- CNT_W, default 16: width of the delivered-word counter.

Ports:
- clk  input  1  sole clock; everything samples on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  in_idx/in_none are valid this cycle.
- in_ready  output  1  block can accept a word this cycle.
- in_idx  input  IDX_W  bit index to set in the output.
- in_none  input  1  1 = produce all-zero word; in_idx is ignored.
- out_valid  output  1  out_onehot holds a word.
- out_ready  input  1  consumer takes the word this cycle.
- out_onehot  output  OUT_W  decoded word: exactly one bit set, or zero when none.
- out_count  output  CNT_W  number of completed output transfers, wraps.

## Operation
- Input transfer: in_valid && in_ready. Output transfer: out_valid && out_ready.
- Decode: out_onehot = in_none ? 0 : (1 << in_idx). Decoding happens on entry, so both storage entries hold already-decoded OUT_W words.
- Storage has two entries:
  - OUT register, which drives the outputs.
  - SKID register, which holds one word while the output is stalled.
- State machine (occupancy):
  - EMPTY: out_valid=0, in_ready=1. Input transfer loads OUT and goes to ONE.
  - ONE: out_valid=1, in_ready=1.
    - Input and output transfer together: OUT loads the new word; stay in ONE.
    - Input transfer only: new word goes to SKID; go to FULL.
    - Output transfer only: go to EMPTY.
  - FULL: out_valid=1, in_ready=0.
    - Output transfer: SKID moves to OUT; go to ONE.
    - No input is accepted while in FULL.
- in_ready is a registered function of state (1 in EMPTY and ONE). It has no combinational path from out_ready.
- out_count increments by 1 on each output transfer, is modulo 2**CNT_W, and wraps from all-ones to 0 silently.
- Order is strictly FIFO; no word is dropped or duplicated.
- in_valid while in_ready=0 has no effect. The source must hold the word until it is accepted.

## Timing
- Reset (rst=1 at a clock edge):
  - state EMPTY, out_valid=0, in_ready=1, out_onehot=0, SKID=0, out_count=0.
  - Reset applies mid-stream regardless of occupancy. Stored words are discarded and the counter clears.
  - While rst=1, inputs are ignored and no transfers count.
- Latency:
  - From EMPTY, a word accepted at edge N appears on out_valid/out_onehot after edge N, i.e. it is visible in cycle N+1.
  - With out_ready held high, one word per cycle passes through with 1-cycle latency and in_ready stays 1.
- Backpressure: out_ready=0 with continuous input gives one more accepted word (into SKID), then in_ready=0 starting the cycle after.
- Release: the first output transfer from FULL raises in_ready the next cycle. No bubble appears on the output side.
- out_onehot and out_valid are register outputs only, with no combinational path from inputs.
- out_onehot is stable while out_valid=1 and out_ready=0.

## Structure
- Shared package decoder_pkg holds:
  - the IDX_W/OUT_W defaults;
  - the state enum (EMPTY, ONE, FULL);
  - a decode function (idx, none) -> one-hot, reusable by the encoder bench as its reference model.
- Sub-module skid_buf2 (parameter W; holds the two registers and the state machine) is natural. The top level instantiates it with W=OUT_W, plus the decode function and the counter.

## Test plan
- Reset, then idx 0..7 with none=0 and out_ready=1 → out_onehot 8'h01, 02, 04 … 80, each one cycle after acceptance; out_count=8.
- in_none=1 with in_idx=3'd5 → out_onehot=8'h00, out_valid=1.
- out_ready=0, three back-to-back words idx 2, 4, 6 → first two accepted, in_ready=0 after the second. Releasing out_ready gives 8'h04, 8'h10 in order, then 8'h40 is accepted and emitted.
- Alternate out_ready 1/0 each cycle with continuous random input → output order matches input order, no loss or duplication. Compare against decoder_pkg decode.
- Assert rst in FULL → the next cycle has out_valid=0, in_ready=1, out_count=0; the first post-reset word emerges alone.
- Preload the count path with 2**CNT_W − 1 transfers (CNT_W=4 override: 15 transfers) → the 16th transfer wraps out_count to 0.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared definitions for the one-hot decoder family: default widths,
// occupancy state encoding and the index-to-one-hot decode rule.
package decoder_pkg;

    localparam int IDX_W_DEF = 3;
    localparam int OUT_W_DEF = 2 ** IDX_W_DEF;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } occ_state_e;

    // One bit of a decoded word: bit `pos` is set only when `idx` selects it
    // and the none flag is clear. Width-independent so any OUT_W can use it.
    function automatic logic onehot_bit(input int unsigned idx,
                                        input logic        none,
                                        input int unsigned pos);
        return !none && (idx == pos);
    endfunction

    // Default-width decode: none ? 0 : (1 << idx).
    function automatic logic [OUT_W_DEF-1:0] decode(input logic [IDX_W_DEF-1:0] idx,
                                                    input logic                 none);
        logic [OUT_W_DEF-1:0] word;
        for (int i = 0; i < OUT_W_DEF; i++) begin
            word[i] = onehot_bit(32'(idx), none, i);
        end
        return word;
    endfunction

endpackage

// File: rtl/skid_buf2.sv
// Two-entry skid buffer: OUT register drives the consumer, SKID catches the
// one extra word accepted while the output is stalled. in_ready and
// out_valid are registered so neither side sees a combinational path.
module skid_buf2
    import decoder_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    occ_state_e   state_q, state_d;
    logic         in_ready_q, in_ready_d;
    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_q, out_d;
    logic [W-1:0] skid_q, skid_d;
    logic         in_xfer;
    logic         out_xfer;

    assign in_xfer  = in_valid && in_ready_q;
    assign out_xfer = out_valid_q && out_ready;

    // Next occupancy and storage contents from the two handshakes.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (in_xfer) begin
                    out_d   = in_data;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_xfer && out_xfer) begin
                    out_d = in_data;
                end else if (in_xfer) begin
                    skid_d  = in_data;
                    state_d = ST_FULL;
                end else if (out_xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only the drain can happen.
                if (out_xfer) begin
                    out_d   = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Handshake flags are decoded from the next state so they are
        // already correct in the cycle the state takes effect.
        in_ready_d  = (state_d != ST_FULL);
        out_valid_d = (state_d != ST_EMPTY);
    end

    // State machine and storage registers; reset discards stored words.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            skid_q      <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            skid_q      <= skid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_q;

endmodule

// File: rtl/decoder3_8_stream.sv
// Registered index-to-one-hot decoder with valid/ready stream ports.
// Words are decoded on entry, buffered two deep, and every delivered word
// bumps a wrapping debug counter.
module decoder3_8_stream
    import decoder_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IDX_W-1:0]      in_idx,
    input  logic                  in_none,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2**IDX_W-1:0]   out_onehot,
    output logic [CNT_W-1:0]      out_count
);

    localparam int OUT_W = 2 ** IDX_W;

    logic [OUT_W-1:0] dec_word;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Decode the incoming index; none forces the all-zero word.
    always_comb begin
        dec_word = '0;
        for (int i = 0; i < OUT_W; i++) begin
            dec_word[i] = onehot_bit(32'(in_idx), in_none, i);
        end
    end

    skid_buf2 #(
        .W (OUT_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (dec_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_onehot)
    );

    // Count completed output transfers; wraps silently at 2**CNT_W.
    always_comb begin
        cnt_d = cnt_q;
        if (out_valid && out_ready) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Delivered-word counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign out_count = cnt_q;

endmodule

// File: tb/tb_decoder3_8_stream.sv
// Bench for decoder3_8_stream: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_decoder3_8_stream;
    import decoder_pkg::*;

    localparam int CNT_W   = 4;
    localparam int CNT_MOD = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] in_idx = 3'd0;
    logic       in_none = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_onehot;
    logic [3:0] out_count;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    decoder3_8_stream #(
        .IDX_W (3),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_idx     (in_idx),
        .in_none    (in_none),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_onehot (out_onehot),
        .out_count  (out_count)
    );

    always #5 clk = ~clk;

    // Reference model: a FIFO of at most two decoded words plus a counter.
    logic [7:0] mq[$];
    int         m_cnt = 0;
    bit         m_acc = 1'b0;

    always @(posedge clk) begin : model
        bit pop;
        if (rst) begin
            mq.delete();
            m_cnt = 0;
            m_acc = 1'b0;
        end else begin
            pop   = (mq.size() > 0) && out_ready;
            m_acc = in_valid && (mq.size() < 2);
            if (pop) begin
                void'(mq.pop_front());
                m_cnt = (m_cnt + 1) % CNT_MOD;
            end
            if (m_acc) begin
                mq.push_back(in_none ? 8'h00 : 8'(1 << in_idx));
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_in_ready", 32'(in_ready), 32'(mq.size() < 2));
            chk("m_out_valid", 32'(out_valid), 32'(mq.size() > 0));
            if (mq.size() > 0) begin
                chk("m_out_onehot", 32'(out_onehot), 32'(mq[0]));
            end
            chk("m_out_count", 32'(out_count), 32'(m_cnt));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    logic [7:0] onehot_tbl [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

    initial begin
        // Pin the package decode rule to literal values.
        chk("pkg_decode_5", 32'(decode(3'd5, 1'b0)), 32'h20);
        chk("pkg_decode_none", 32'(decode(3'd5, 1'b1)), 32'h00);
        chk("pkg_decode_0", 32'(decode(3'd0, 1'b0)), 32'h01);

        step();
        do_reset();
        chk_en = 1'b1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_onehot", 32'(out_onehot), 32'h00);
        chk("rst_out_count", 32'(out_count), 32'd0);

        // Pass-through of every index with 1-cycle latency.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_idx   = 3'(i);
            in_none  = 1'b0;
            step();
            chk("pass_valid", 32'(out_valid), 32'd1);
            chk("pass_onehot", 32'(out_onehot), 32'(onehot_tbl[i]));
            chk("pass_in_ready", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        step();
        chk("pass_count8", 32'(out_count), 32'd8);
        chk("pass_drained", 32'(out_valid), 32'd0);

        // None flag yields a valid all-zero word.
        in_valid = 1'b1;
        in_idx   = 3'd5;
        in_none  = 1'b1;
        step();
        in_valid = 1'b0;
        in_none  = 1'b0;
        chk("none_valid", 32'(out_valid), 32'd1);
        chk("none_onehot", 32'(out_onehot), 32'h00);
        step();

        // Backpressure: idx 2 and 4 accepted, idx 6 held off.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_idx    = 3'd2;
        step();
        chk("bp_first_ready", 32'(in_ready), 32'd1);
        in_idx = 3'd4;
        step();
        chk("bp_full_ready", 32'(in_ready), 32'd0);
        in_idx = 3'd6;
        step();
        chk("bp_hold_ready", 32'(in_ready), 32'd0);
        chk("bp_hold_onehot", 32'(out_onehot), 32'h04);
        out_ready = 1'b1;
        step();
        chk("bp_rel_onehot", 32'(out_onehot), 32'h10);
        chk("bp_rel_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("bp_last_onehot", 32'(out_onehot), 32'h40);
        chk("bp_last_valid", 32'(out_valid), 32'd1);
        step();
        chk("bp_done_valid", 32'(out_valid), 32'd0);

        // Alternating out_ready with random input, source holds until accepted.
        in_valid = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!in_valid || m_acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_idx   = 3'($urandom_range(0, 7));
                in_none  = ($urandom_range(0, 7) == 0);
            end
            out_ready = (c % 2 == 0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        step();

        // Reset while FULL discards both words and clears the counter.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_idx    = 3'd3;
        step();
        in_idx = 3'd7;
        step();
        chk("full_before_rst", 32'(in_ready), 32'd0);
        do_reset();
        chk("postrst_valid", 32'(out_valid), 32'd0);
        chk("postrst_ready", 32'(in_ready), 32'd1);
        chk("postrst_count", 32'(out_count), 32'd0);
        in_idx    = 3'd1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("postrst_word", 32'(out_onehot), 32'h02);
        step();
        chk("postrst_alone", 32'(out_valid), 32'd0);
        chk("postrst_cnt1", 32'(out_count), 32'd1);

        // Counter wrap with a 4-bit counter: 16th transfer returns to 0.
        do_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_idx = 3'(i);
            step();
        end
        chk("wrap_cnt15", 32'(out_count), 32'd15);
        in_valid = 1'b0;
        step();
        chk("wrap_cnt0", 32'(out_count), 32'd0);
        step();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
